// File: rtl/rf_pkg.sv
// Shared register-file constants for the writeback arbiter and its scoreboard.
package rf_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    function automatic logic is_real_reg(input logic [ADDR_W-1:0] r);
        return r != REG_ZERO;
    endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback sources, scoreboard issue/lookup and register-file write port bundle.
interface rf_wb_arbiter_if;
    import rf_pkg::*;

    logic              p0_valid, p0_ready;
    logic [ADDR_W-1:0] p0_rd;
    logic [DATA_W-1:0] p0_data;
    logic              p1_valid, p1_ready;
    logic [ADDR_W-1:0] p1_rd;
    logic [DATA_W-1:0] p1_data;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_set_rd;
    logic [ADDR_W-1:0] rs_a, rs_b;
    logic              busy_a, busy_b, sb_overlap;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rw;
    logic [DATA_W-1:0] rf_w;

    modport slave (
        input  p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
               sb_set, sb_set_rd, rs_a, rs_b,
        output p0_ready, p1_ready, busy_a, busy_b, sb_overlap, rf_we, rf_rw, rf_w
    );

    modport master (
        output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
               sb_set, sb_set_rd, rs_a, rs_b,
        input  p0_ready, p1_ready, busy_a, busy_b, sb_overlap, rf_we, rf_rw, rf_w
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write bits for multi-cycle destinations plus RAW busy lookups for decode.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_rd_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_rd_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_rd_i,
    input  logic [ADDR_W-1:0] rs_a_i,
    input  logic [ADDR_W-1:0] rs_b_i,
    output logic              busy_a_o,
    output logic              busy_b_o,
    output logic              overlap_o
);
    logic [NREG-1:0] pending_q, pending_d;
    logic            overlap_q;
    logic            set_ok;

    assign set_ok = set_i & is_real_reg(set_rd_i);

    // Clear is applied first so a same-cycle set on the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_i)
            pending_d[clr_rd_i] = 1'b0;
        if (set_ok)
            pending_d[set_rd_i] = 1'b1;
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            overlap_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overlap_q <= set_ok & pending_q[set_rd_i];
        end
    end

    // The write in flight on the register-file port is still invisible to reads.
    function automatic logic busy_of(input logic [ADDR_W-1:0] rs);
        return is_real_reg(rs) & (pending_q[rs] | (wr_en_i & (wr_rd_i == rs)));
    endfunction

    assign busy_a_o  = busy_of(rs_a_i);
    assign busy_b_o  = busy_of(rs_b_i);
    assign overlap_o = overlap_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-source arbiter for the register file write port with starvation guard for MUL/DIV.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              force1, g0, g1, grant;
    logic [ADDR_W-1:0] gnt_rd;
    logic [DATA_W-1:0] gnt_data;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_rw_q;
    logic [DATA_W-1:0] rf_w_q;

    // Source 0 wins by default; once source 1 has waited STARVE_LIMIT cycles it goes first.
    assign force1        = (starve_q == CNT_W'(STARVE_LIMIT));
    assign bus.p0_ready  = ~force1;
    assign bus.p1_ready  = force1 | ~bus.p0_valid;
    assign g0            = bus.p0_valid & ~force1;
    assign g1            = bus.p1_valid & (force1 | ~bus.p0_valid);
    assign grant         = g0 | g1;
    assign gnt_rd        = g1 ? bus.p1_rd   : bus.p0_rd;
    assign gnt_data      = g1 ? bus.p1_data : bus.p0_data;

    always_comb begin
        starve_d = starve_q;
        if (!bus.p1_valid || g1)
            starve_d = '0;
        else if (!force1)
            starve_d = starve_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            rf_we_q  <= 1'b0;
            rf_rw_q  <= '0;
            rf_w_q   <= '0;
        end else begin
            starve_q <= starve_d;
            rf_we_q  <= grant & is_real_reg(gnt_rd);
            if (grant) begin
                rf_rw_q <= gnt_rd;
                rf_w_q  <= gnt_data;
            end
        end
    end

    rf_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_i     (bus.sb_set),
        .set_rd_i  (bus.sb_set_rd),
        .clr_i     (g1),
        .clr_rd_i  (bus.p1_rd),
        .wr_en_i   (rf_we_q),
        .wr_rd_i   (rf_rw_q),
        .rs_a_i    (bus.rs_a),
        .rs_b_i    (bus.rs_b),
        .busy_a_o  (bus.busy_a),
        .busy_b_o  (bus.busy_b),
        .overlap_o (bus.sb_overlap)
    );

    assign bus.rf_we = rf_we_q;
    assign bus.rf_rw = rf_rw_q;
    assign bus.rf_w  = rf_w_q;
endmodule
